// File: rtl/ldst_if.sv
// Load/store request/response channel between a core LSU (master) and a
// local memory responder (slave). Both directions use valid/ready handshakes.
interface ldst_if;
    logic        req_vld;
    logic        req_rdy;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_strb;
    logic        req_wr;

    logic        rsp_vld;
    logic        rsp_rdy;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_vld, req_addr, req_wdata, req_strb, req_wr, rsp_rdy,
        input  req_rdy, rsp_vld, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_vld, req_addr, req_wdata, req_strb, req_wr, rsp_rdy,
        output req_rdy, rsp_vld, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/ldst_mem.sv
// Local word-addressed data memory with byte-strobed stores and an in-order
// response FIFO. Optional address/alignment checking under LDST_MEM_ERR_EN.
module ldst_mem #(
    parameter int DEPTH_WORDS = 1024,
    parameter int RSP_Q_DEPTH = 2
) (
    input  logic   clk,
    input  logic   rst,
    ldst_if.slave  ldst_slv
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int PW = (RSP_Q_DEPTH > 1) ? $clog2(RSP_Q_DEPTH) : 1;
    localparam int CW = $clog2(RSP_Q_DEPTH + 1);

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t Q_DEPTH  = cnt_t'(RSP_Q_DEPTH);
    localparam ptr_t PTR_LAST = ptr_t'(RSP_Q_DEPTH - 1);

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rd_word;

    logic [31:0] q_rdata [RSP_Q_DEPTH];
    logic        q_err   [RSP_Q_DEPTH];
    ptr_t        wr_ptr;
    ptr_t        rd_ptr;
    cnt_t        count;

    logic        rdy_en;
    logic        infl_vld;
    logic        infl_ld;
    logic        infl_err;
    logic [31:0] infl_rdata;

    logic        accept;
    logic        pop;
    logic        push;
    logic        q_pop;
    logic        q_empty;
    logic        req_err;
    logic [AW-1:0] idx;
    logic [31:0] head_rdata;
    logic        head_err;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == PTR_LAST) ? '0 : ptr_t'(p + 1'b1);
    endfunction

    assign idx = ldst_slv.req_addr[AW+1:2];

`ifdef LDST_MEM_ERR_EN
    logic [1:0] low_lane;
    logic       addr_oob;

    always_comb begin
        low_lane = 2'd0;
        if (ldst_slv.req_strb[0])      low_lane = 2'd0;
        else if (ldst_slv.req_strb[1]) low_lane = 2'd1;
        else if (ldst_slv.req_strb[2]) low_lane = 2'd2;
        else if (ldst_slv.req_strb[3]) low_lane = 2'd3;
    end

    assign addr_oob = |ldst_slv.req_addr[31:AW+2];
    assign req_err  = addr_oob ||
                      (ldst_slv.req_wr && (ldst_slv.req_addr[1:0] != low_lane));
`else
    logic unused_addr;
    assign unused_addr = ^{ldst_slv.req_addr[31:AW+2], ldst_slv.req_addr[1:0]};
    assign req_err     = 1'b0;
`endif

    // Ready comes only from registered state, so there is no path from
    // req_vld or rsp_rdy into req_rdy.
    assign ldst_slv.req_rdy = rdy_en && ((count + cnt_t'(infl_vld)) < Q_DEPTH);
    assign accept           = ldst_slv.req_vld && ldst_slv.req_rdy;

    always_ff @(posedge clk) begin
        if (accept && ldst_slv.req_wr && !req_err) begin
            for (int b = 0; b < 4; b++) begin
                if (ldst_slv.req_strb[b])
                    mem[idx][8*b +: 8] <= ldst_slv.req_wdata[8*b +: 8];
            end
        end
        if (accept && !ldst_slv.req_wr)
            rd_word <= mem[idx];
    end

    // The in-flight slot holds the response of the request accepted last
    // cycle; it bypasses the FIFO when the FIFO is empty.
    assign infl_rdata = (infl_ld && !infl_err) ? rd_word : 32'd0;
    assign q_empty    = (count == cnt_t'(0));

    assign head_rdata = q_empty ? infl_rdata : q_rdata[rd_ptr];
    assign head_err   = q_empty ? infl_err   : q_err[rd_ptr];

    assign ldst_slv.rsp_vld   = !q_empty || infl_vld;
    assign ldst_slv.rsp_rdata = ldst_slv.rsp_vld ? head_rdata : 32'd0;
    assign ldst_slv.rsp_err   = ldst_slv.rsp_vld && head_err;

    assign pop   = ldst_slv.rsp_vld && ldst_slv.rsp_rdy;
    assign q_pop = pop && !q_empty;
    assign push  = infl_vld && !(pop && q_empty);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_en   <= 1'b0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            infl_vld <= 1'b0;
            infl_ld  <= 1'b0;
            infl_err <= 1'b0;
        end else begin
            rdy_en   <= 1'b1;
            infl_vld <= accept;
            if (accept) begin
                infl_ld  <= !ldst_slv.req_wr;
                infl_err <= req_err;
            end
            if (push)  wr_ptr <= ptr_inc(wr_ptr);
            if (q_pop) rd_ptr <= ptr_inc(rd_ptr);
            count <= count + cnt_t'(push) - cnt_t'(q_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_rdata[wr_ptr] <= infl_rdata;
            q_err[wr_ptr]   <= infl_err;
        end
    end
endmodule

// File: tb/tb_ldst_mem.sv
// Directed bench for ldst_mem: table of single request/response vectors plus
// hand-written backpressure, streaming and reset sequences.
module tb_ldst_mem;
    localparam int DEPTH_WORDS = 1024;
    localparam int RSP_Q_DEPTH = 2;

    logic clk;
    logic rst;
    ldst_if ldst ();

    ldst_mem #(.DEPTH_WORDS(DEPTH_WORDS), .RSP_Q_DEPTH(RSP_Q_DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .ldst_slv (ldst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic        wr;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] ld_addr[16];
    logic [31:0] ld_exp[16];
    int          n_vec  = 0;
    int          n_miss = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Issue one request with rsp_rdy high and check its response one cycle later.
    task automatic do_req(input string nm, input vec_t v);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        ldst.rsp_rdy   = 1'b1;
        ldst.req_vld   = 1'b1;
        ldst.req_addr  = v.addr;
        ldst.req_wdata = v.wdata;
        ldst.req_strb  = v.strb;
        ldst.req_wr    = v.wr;
        for (int i = 0; i < 50; i++) begin
            if (ldst.req_rdy) begin
                @(posedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        #1;
        ldst.req_vld = 1'b0;
        if (!ok) begin
            chk({nm, "_accept_timeout"}, 32'd0, 32'd1);
        end else begin
            chk({nm, "_vld"},   {31'd0, ldst.rsp_vld}, 32'd1);
            chk({nm, "_rdata"}, ldst.rsp_rdata, v.exp_rdata);
            chk({nm, "_err"},   {31'd0, ldst.rsp_err}, {31'd0, v.exp_err});
        end
    endtask

    // Stream n loads from ld_addr[]; rsp_rdy is held low for the first
    // `stall` cycles. With stall==0, load i is accepted in cycle i and its
    // response appears in cycle i+1.
    task automatic stream(input string nm, input int n, input int stall);
        int sent;
        int got;
        sent = 0;
        got  = 0;
        @(negedge clk);
        @(negedge clk);
        ldst.rsp_rdy = (stall == 0);
        for (int cyc = 0; cyc < 200 && got < n; cyc++) begin
            @(negedge clk);
            if (stall > 0 && cyc == stall) begin
                chk({nm, "_accepted_while_stalled"}, sent, RSP_Q_DEPTH);
                chk({nm, "_rdy_low_when_full"}, {31'd0, ldst.req_rdy}, 32'd0);
                ldst.rsp_rdy = 1'b1;
            end
            if (ldst.rsp_vld && ldst.rsp_rdy) begin
                chk($sformatf("%s_rsp%0d", nm, got), ldst.rsp_rdata, ld_exp[got]);
                if (stall == 0) chk($sformatf("%s_rsp%0d_cycle", nm, got), cyc, got + 1);
                got++;
            end
            if (sent < n) begin
                ldst.req_vld  = 1'b1;
                ldst.req_wr   = 1'b0;
                ldst.req_strb = 4'h0;
                ldst.req_addr = ld_addr[sent];
                if (ldst.req_rdy) begin
                    if (stall == 0) chk($sformatf("%s_acc%0d_cycle", nm, sent), cyc, sent);
                    sent++;
                end
            end else begin
                ldst.req_vld = 1'b0;
            end
        end
        ldst.req_vld = 1'b0;
        chk({nm, "_rsp_count"}, got, n);
        @(negedge clk);
        chk({nm, "_no_extra_rsp"}, {31'd0, ldst.rsp_vld}, 32'd0);
    endtask

    initial begin
        ldst.req_vld   = 1'b0;
        ldst.req_addr  = '0;
        ldst.req_wdata = '0;
        ldst.req_strb  = '0;
        ldst.req_wr    = 1'b0;
        ldst.rsp_rdy   = 1'b1;
        rst = 1'b1;

        vecs.push_back('{32'h10,  32'hDEADBEEF, 4'hF, 1'b1, 32'h0,        1'b0});
        vecs.push_back('{32'h10,  32'h0,        4'h0, 1'b0, 32'hDEADBEEF, 1'b0});
        vecs.push_back('{32'h20,  32'h11223344, 4'hF, 1'b1, 32'h0,        1'b0});
        vecs.push_back('{32'h21,  32'hAABBCCDD, 4'h2, 1'b1, 32'h0,        1'b0});
        vecs.push_back('{32'h20,  32'h0,        4'hF, 1'b0, 32'h1122CC44, 1'b0});
        vecs.push_back('{32'h23,  32'h0,        4'h0, 1'b0, 32'h1122CC44, 1'b0});
        vecs.push_back('{32'h40,  32'h0,        4'hF, 1'b1, 32'h0,        1'b0});
        vecs.push_back('{32'h40,  32'hFFFFFFFF, 4'h9, 1'b1, 32'h0,        1'b0});
        vecs.push_back('{32'h40,  32'h0,        4'h0, 1'b0, 32'hFF0000FF, 1'b0});
        vecs.push_back('{32'hFFC, 32'h5A5A1234, 4'hF, 1'b1, 32'h0,        1'b0});
        vecs.push_back('{32'hFFC, 32'h0,        4'h0, 1'b0, 32'h5A5A1234, 1'b0});
`ifdef LDST_MEM_ERR_EN
        vecs.push_back('{32'h1000, 32'h0,        4'h0, 1'b0, 32'h0,        1'b1});
        vecs.push_back('{32'h30,   32'h01020304, 4'hF, 1'b1, 32'h0,        1'b0});
        vecs.push_back('{32'h31,   32'hFFFFFFFF, 4'h4, 1'b1, 32'h0,        1'b1});
        vecs.push_back('{32'h30,   32'h0,        4'h0, 1'b0, 32'h01020304, 1'b0});
`else
        vecs.push_back('{32'h1010, 32'h0,        4'h0, 1'b0, 32'hDEADBEEF, 1'b0});
`endif

        #22;
        chk("rst_req_rdy",   {31'd0, ldst.req_rdy}, 32'd0);
        chk("rst_rsp_vld",   {31'd0, ldst.rsp_vld}, 32'd0);
        chk("rst_rsp_rdata", ldst.rsp_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_rdy_before_edge", {31'd0, ldst.req_rdy}, 32'd0);
        @(posedge clk);
        #1;
        chk("post_rst_rdy_first_edge", {31'd0, ldst.req_rdy}, 32'd1);

        foreach (vecs[i]) do_req($sformatf("vec%0d", i), vecs[i]);

        for (int i = 0; i < 16; i++) begin
            ld_addr[i] = 32'h200 + 32'(4 * i);
            ld_exp[i]  = 32'hC0DE0000 + 32'(i);
            do_req($sformatf("fill%0d", i), '{ld_addr[i], ld_exp[i], 4'hF, 1'b1, 32'h0, 1'b0});
        end

        stream("backpressure", 4, 6);
        stream("stream16", 16, 0);

        // Reset with two responses pending.
        @(negedge clk);
        ldst.rsp_rdy  = 1'b0;
        ldst.req_vld  = 1'b1;
        ldst.req_wr   = 1'b0;
        ldst.req_addr = ld_addr[0];
        @(negedge clk);
        ldst.req_addr = ld_addr[1];
        @(negedge clk);
        ldst.req_vld = 1'b0;
        chk("pre_rst_rsp_vld", {31'd0, ldst.rsp_vld}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_rsp_vld",   {31'd0, ldst.rsp_vld}, 32'd0);
        chk("mid_rst_req_rdy",   {31'd0, ldst.req_rdy}, 32'd0);
        chk("mid_rst_rsp_rdata", ldst.rsp_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ldst.rsp_rdy = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_rdy_rise", {31'd0, ldst.req_rdy}, 32'd1);
        do_req("after_rst_st", '{32'h10, 32'hCAFEF00D, 4'hF, 1'b1, 32'h0, 1'b0});
        do_req("after_rst_ld", '{32'h10, 32'h0, 4'h0, 1'b0, 32'hCAFEF00D, 1'b0});
        @(negedge clk);
        @(negedge clk);
        chk("after_rst_only_own", {31'd0, ldst.rsp_vld}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/ldst_mem.md
LDST_MEM -- requirements
Module: ldst_mem

Interface
REQ-001 Parameter: DEPTH_WORDS, 1024, number of 32-bit words in the local data array (power of two).
REQ-002 Parameter: RSP_Q_DEPTH, 2, response queue entries (>=2).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset; reset is asynchronous and active-high.
REQ-005 Port: ldst_slv  ldst_if.slave  -  request/response channel, responder end of the ldst protocol driven by the core LSU.
REQ-006 Field: req_vld/req_rdy  1/1  request handshake; req_pkt = {addr[31:0], wdata[31:0], strb[3:0], wr[0]}.
REQ-007 Field: rsp_vld/rsp_rdy  1/1  response handshake; rsp_pkt = {rdata[31:0], err[0]}.

Function
REQ-008 The block SHALL accept a request only on a cycle where req_vld and req_rdy are both high.
REQ-009 Word index SHALL be addr[log2(DEPTH_WORDS)+1:2]; addr[1:0] SHALL be ignored for data placement.
REQ-010 On an accepted store (wr=1), bytes with strb[i]=1 SHALL be written with wdata[8i+7:8i] at the clock edge of acceptance; other bytes unchanged.
REQ-011 On an accepted load (wr=0), the full 32-bit word SHALL be read; strb SHALL be ignored.
REQ-012 Every accepted request SHALL produce exactly one response, in acceptance order; store responses carry rdata=0.
REQ-013 Minimum latency SHALL be one cycle: request accepted in cycle N yields rsp_vld high in cycle N+1 if the queue is otherwise empty.
REQ-014 Read-after-write: a load accepted the cycle after a store to the same word SHALL return the stored data.
REQ-015 Responses SHALL be held in a FIFO of RSP_Q_DEPTH entries; rsp_vld = queue non-empty; rsp_pkt = head entry, stable while rsp_vld && !rsp_rdy.
REQ-016 req_rdy SHALL be high iff (queue occupancy + in-flight read) < RSP_Q_DEPTH; req_rdy SHALL NOT depend combinationally on req_vld.
REQ-017 Simultaneous push and pop SHALL leave occupancy unchanged; full queue with pop SHALL allow acceptance in the same cycle only if rule REQ-016 holds at that cycle's start (no combinational rsp_rdy->req_rdy path).
REQ-018 Pointers SHALL wrap modulo RSP_Q_DEPTH without loss or duplication.
REQ-019 Sustained throughput SHALL be one request per cycle while rsp_rdy is held high.

Reset
REQ-020 During rst: req_rdy=0, rsp_vld=0, rsp_pkt=0, queue occupancy=0, pointers=0, in-flight flag=0.
REQ-021 After rst deasserts, req_rdy SHALL rise on the first clk edge.
REQ-022 Reset mid-transaction SHALL discard queued and in-flight responses; array contents SHALL be undefined after reset, never reset-cleared.

Configuration
REQ-023 Macro LDST_MEM_ERR_EN: when defined, a request with addr outside [0, 4*DEPTH_WORDS) or, for stores, misaligned to the strb pattern (addr[1:0] != index of lowest set strb bit) SHALL return err=1, rdata=0, and SHALL NOT modify the array.
REQ-024 Without LDST_MEM_ERR_EN, upper address bits SHALL be ignored (address wraps modulo array size), no check logic is built, and err SHALL be constant 0.

Verification
REQ-025 Store addr=0x10 wdata=0xDEADBEEF strb=0xF, then load 0x10 next cycle -> rsp rdata=0xDEADBEEF err=0, one cycle after load acceptance.
REQ-026 Store 0x20 wdata=0x11223344 strb=0xF, store 0x20 wdata=0xAABBCCDD strb=0x2, load 0x20 -> rdata=0x1122CC44.
REQ-027 rsp_rdy=0, issue 4 loads back-to-back -> exactly RSP_Q_DEPTH=2 accepted, req_rdy low; raise rsp_rdy -> all 4 responses in order, none lost.
REQ-028 rsp_rdy=1, 16 consecutive loads -> 16 accepted in 16 cycles, responses each following cycle.
REQ-029 Assert rst with 2 responses queued -> rsp_vld=0 immediately; after release, next load returns only its own response.
REQ-030 With LDST_MEM_ERR_EN, load addr=4*DEPTH_WORDS -> err=1 rdata=0; store strb=0x4 addr=0x31 -> err=1, word 0x30 unchanged on readback.
